// File: rtl/bsk_prd_master_if.sv
// ---------------------------------------------------------------------------
// bsk_prd_master_if
//   Signal bundle for the BSK PRD bus initiator.
//
//   Host side (request in, status out):
//     iReq, iWe, iCsSel[3:0], iAdr[1:0], iWData[15:0]
//     oRData[15:0], oCom[7:0], oChkErr, oDone, oBusy
//   Backplane control (driven by the initiator):
//     oRd (active low), oWr (active low), oA[1:0], oCS[3:0]
//
//   The bidirectional data bus bD is a plain inout port of the initiator,
//   so its tristate resolution stays visible at the level where the
//   board drivers are connected.
//
//   modport master : the initiator (bsk_prd_master)
//   modport slave  : whoever drives requests and watches the bus
// ---------------------------------------------------------------------------
interface bsk_prd_master_if;

  // host request
  logic        iReq;
  logic        iWe;
  logic [3:0]  iCsSel;
  logic [1:0]  iAdr;
  logic [15:0] iWData;

  // host status / results
  logic [15:0] oRData;
  logic [7:0]  oCom;
  logic        oChkErr;
  logic        oDone;
  logic        oBusy;

  // backplane control
  logic        oRd;
  logic        oWr;
  logic [1:0]  oA;
  logic [3:0]  oCS;

  modport master (
    input  iReq, iWe, iCsSel, iAdr, iWData,
    output oRData, oCom, oChkErr, oDone, oBusy,
    output oRd, oWr, oA, oCS
  );

  modport slave (
    output iReq, iWe, iCsSel, iAdr, iWData,
    input  oRData, oCom, oChkErr, oDone, oBusy,
    input  oRd, oWr, oA, oCS
  );

endinterface

// File: rtl/bsk_prd_master.sv
// ---------------------------------------------------------------------------
// bsk_prd_master
//   Bus initiator for the BSK PRD parallel peripheral bus. Turns one host
//   request into a timed SETUP -> STROBE -> HOLD cycle on the backplane and
//   validates read data coming back from the PRD board.
//
//   Ports:
//     clk   : system clock
//     aclr  : asynchronous active-high reset; releases the bus at once
//     bus   : bsk_prd_master_if.master
//               host : iReq/iWe/iCsSel/iAdr/iWData in,
//                      oRData/oCom/oChkErr/oDone/oBusy out
//               bus  : oRd/oWr (active low), oA, oCS
//     bD    : 16-bit bidirectional bus data, driven only on write cycles
//
//   Read checks (reported with the oDone pulse):
//     adr 0/1 : high nibble of each byte must be the complement of the low
//               nibble; a clean word updates oCom = {r[11:8], r[3:0]}
//     adr 3   : r[15:8] must equal PASSWORD
//     adr 2 and all writes : never flagged
// ---------------------------------------------------------------------------
module bsk_prd_master #(
  parameter int unsigned T_SETUP  = 1,      // 1..15
  parameter int unsigned T_STROBE = 2,      // 1..15
  parameter int unsigned T_HOLD   = 1,      // 1..15
  parameter logic [3:0]  CS_IDLE  = 4'hF,
  parameter logic [7:0]  PASSWORD = 8'hA4
) (
  input  logic                    clk,
  input  logic                    aclr,
  bsk_prd_master_if.master        bus,
  inout  wire  [15:0]             bD
);

  // Phase lengths as counter reload values (the counter runs down to 0).
  localparam logic [3:0] SETUP_LD  = 4'(T_SETUP  - 1);
  localparam logic [3:0] STROBE_LD = 4'(T_STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(T_HOLD   - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields latched at acceptance.
  logic        we_q, we_d;
  logic [3:0]  cs_q, cs_d;
  logic [1:0]  adr_q, adr_d;
  logic [15:0] wdata_q, wdata_d;

  // Registered bus-side outputs.
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [1:0]  a_out_q, a_out_d;
  logic [3:0]  cs_out_q, cs_out_d;
  logic        drive_q, drive_d;

  // Registered host-side outputs.
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  com_q, com_d;
  logic        chkerr_q, chkerr_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Check result on the captured word (only used at the end of HOLD).
  logic        chk_err;
  logic        cmd_err;
  logic        pwd_err;

  assign cmd_err = (rdata_q[7:4]   != ~rdata_q[3:0]) |
                   (rdata_q[15:12] != ~rdata_q[11:8]);
  assign pwd_err = (rdata_q[15:8] != PASSWORD);

  always_comb begin
    chk_err = 1'b0;
    if (!we_q) begin
      case (adr_q)
        2'd0, 2'd1: chk_err = cmd_err;
        2'd3:       chk_err = pwd_err;
        default:    chk_err = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    cs_d     = cs_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    com_d    = com_q;
    chkerr_d = 1'b0;        // only ever high alongside done
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The oDone cycle is an IDLE cycle, so back-to-back requests are
        // accepted here without a gap.
        if (bus.iReq) begin
          we_d    = bus.iWe;
          cs_d    = bus.iCsSel;
          adr_d   = bus.iAdr;
          wdata_d = bus.iWData;
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end

      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Sample on the edge that ends the strobe: the board is still
          // driving because oRd only rises after this edge.
          if (!we_q) begin
            rdata_d = bD;
          end
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_IDLE;
          cnt_d    = 4'd0;
          done_d   = 1'b1;
          chkerr_d = chk_err;
          // A corrupted command word must not overwrite the last good one.
          if (!we_q && !adr_q[1] && !cmd_err) begin
            com_d = {rdata_q[11:8], rdata_q[3:0]};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so the
  // pins change cleanly on the clock edge with no decode glitches. Because
  // the data drive spans SETUP..HOLD and the strobe is low only in STROBE,
  // the bD direction never changes while a strobe is low.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    cs_out_d = busy_d ? cs_d  : CS_IDLE;
    a_out_d  = busy_d ? adr_d : 2'd0;
    rd_n_d   = !((state_d == S_STROBE) && !we_d);
    wr_n_d   = !((state_d == S_STROBE) &&  we_d);
    drive_d  = busy_d && we_d;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      cs_q     <= 4'd0;
      adr_q    <= 2'd0;
      wdata_q  <= 16'd0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_out_q  <= 2'd0;
      cs_out_q <= CS_IDLE;
      drive_q  <= 1'b0;
      rdata_q  <= 16'd0;
      com_q    <= 8'd0;
      chkerr_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      cs_q     <= cs_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_out_q  <= a_out_d;
      cs_out_q <= cs_out_d;
      drive_q  <= drive_d;
      rdata_q  <= rdata_d;
      com_q    <= com_d;
      chkerr_q <= chkerr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign bus.oRd     = rd_n_q;
  assign bus.oWr     = wr_n_q;
  assign bus.oA      = a_out_q;
  assign bus.oCS     = cs_out_q;
  assign bus.oRData  = rdata_q;
  assign bus.oCom    = com_q;
  assign bus.oChkErr = chkerr_q;
  assign bus.oDone   = done_q;
  assign bus.oBusy   = busy_q;

  assign bD = drive_q ? wdata_q : 16'hzzzz;

endmodule
